// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported integer register file with a pending-write
// scoreboard.
//
// Purpose
//   NREG x XLEN architectural registers, one write port and RD_PORTS
//   independent registered read ports. Register 0 is hard-wired to zero.
//   A per-register busy bit tracks instructions that have issued but not
//   yet written back. The busy bit is set by issue_en/issue_rd and cleared
//   by wr_en/rd. When a set and a clear hit the same register on the same
//   edge, the set wins.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-low; clears registers, busy bits, rd_data
//   wr_en     in   commit a write to register rd (writes to x0 are dropped)
//   load      in   write-data select: 1 = memory, 0 = result
//   rd        in   [AW]            write address
//   result    in   [XLEN]          ALU write data
//   memory    in   [XLEN]          load write data
//   rd_en     in   [RD_PORTS]      per-port read strobe
//   rs_addr   in   [RD_PORTS*AW]   packed read addresses, port p at [p*AW +: AW]
//   rd_data   out  [RD_PORTS*XLEN] registered read data, port p at [p*XLEN +: XLEN]
//   issue_en  in   mark issue_rd as pending-write
//   issue_rd  in   [AW]            scoreboard set address
//   rs_busy   out  [RD_PORTS]      combinational pending-write flag for rs_addr[p]
//
// Build option
//   REGFILE_BYPASS_EN: when defined, a read strobed on the same edge as a
//   write to the same non-zero register returns the incoming write data.
//   The matching rs_busy bit is also masked to 0 for that cycle. When the
//   macro is undefined, the read returns the pre-write value and rs_busy is
//   not masked.
//
// Interface timing
//   There is no handshake. Every strobe (wr_en, rd_en, issue_en) acts on the
//   rising edge at which it is sampled high. Read data appears one cycle
//   later and holds until the port is strobed again.

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RD_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     load,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic [XLEN-1:0]          result,
  input  logic [XLEN-1:0]          memory,
  input  logic [RD_PORTS-1:0]      rd_en,
  input  logic [RD_PORTS*$clog2(NREG)-1:0] rs_addr,
  output logic [RD_PORTS*XLEN-1:0] rd_data,
  input  logic                     issue_en,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  output logic [RD_PORTS-1:0]      rs_busy
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]          regs [NREG];
  logic [NREG-1:0]          busy;
  logic [NREG-1:0]          busy_nxt;
  logic [XLEN-1:0]          wr_data;
  logic                     wr_live;
  logic [RD_PORTS*XLEN-1:0] rd_val;

  assign wr_data = load ? memory : result;
  // A write to x0 is architecturally a no-op. It neither stores data nor
  // forwards data.
  assign wr_live = wr_en && (rd != '0);

  // Scoreboard next state. The clear is applied first so that a same-edge
  // issue to the same register overrides it.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[rd] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Per-port read value and busy flag.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rs_addr[p*AW +: AW];
    assign hit = wr_live && (rd == ra);

`ifdef REGFILE_BYPASS_EN
    // Forward the incoming write so that the reader sees the new value. The
    // writer is retiring this cycle, so the register no longer counts as
    // pending for this reader.
    assign rd_val[p*XLEN +: XLEN] = hit ? wr_data
                                  : ((ra == '0) ? '0 : regs[ra]);
    assign rs_busy[p] = busy[ra] && !(rd_en[p] && hit);
`else
    // Without forwarding, the read sees the register before this edge's
    // write. The hit term is unused in this build.
    logic unused_hit;
    assign unused_hit = hit;
    assign rd_val[p*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
    assign rs_busy[p] = busy[ra];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy    <= '0;
      rd_data <= '0;
    end else begin
      if (wr_live) regs[rd] <= wr_data;
      busy <= busy_nxt;
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p]) rd_data[p*XLEN +: XLEN] <= rd_val[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RDP  = 2;
  localparam int AW   = 5;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 wr_en;
  logic                 load;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      result;
  logic [XLEN-1:0]      memory;
  logic [RDP-1:0]       rd_en;
  logic [RDP*AW-1:0]    rs_addr;
  logic [RDP*XLEN-1:0]  rd_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_rd;
  logic [RDP-1:0]       rs_busy;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .RD_PORTS(RDP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .load(load), .rd(rd),
    .result(result), .memory(memory), .rd_en(rd_en), .rs_addr(rs_addr),
    .rd_data(rd_data), .issue_en(issue_en), .issue_rd(issue_rd),
    .rs_busy(rs_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values, the pending set, and
  // the last value delivered to each read port.
  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];
  logic [XLEN-1:0] m_out  [RDP];

  function automatic logic [AW-1:0] addr_of(int p);
    return rs_addr[p*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] out_of(int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  // Expected pending flag seen by a reader under the current inputs.
  function automatic bit model_busy(int p);
    bit b;
    b = m_busy[addr_of(p)];
`ifdef REGFILE_BYPASS_EN
    if (rd_en[p] && wr_en && rd != 0 && rd == addr_of(p)) b = 0;
`endif
    return b;
  endfunction

  // Driver: advance one clock, then apply the architectural effect of the
  // inputs that were sampled on that edge to the model.
  task automatic tick();
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] nxt_out [RDP];
    bit              do_rst;
    bit              s_wr, s_iss, s_load;
    logic [AW-1:0]   s_rd, s_ird;
    logic [XLEN-1:0] s_res, s_mem;
    logic [RDP-1:0]  s_en;
    logic [RDP*AW-1:0] s_addr;
    do_rst = !reset; s_wr = wr_en; s_iss = issue_en; s_load = load;
    s_rd = rd; s_ird = issue_rd; s_res = result; s_mem = memory;
    s_en = rd_en; s_addr = rs_addr;
    @(posedge clk);
    #1;
    if (do_rst) begin
      for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
      for (int p = 0; p < RDP; p++) m_out[p] = '0;
    end else begin
      wd = s_load ? s_mem : s_res;
      for (int p = 0; p < RDP; p++) begin
        logic [AW-1:0] a;
        a = s_addr[p*AW +: AW];
        nxt_out[p] = m_out[p];
        if (s_en[p]) begin
          nxt_out[p] = (a == 0) ? '0 : m_reg[a];
`ifdef REGFILE_BYPASS_EN
          if (s_wr && s_rd != 0 && s_rd == a) nxt_out[p] = wd;
`endif
        end
      end
      for (int p = 0; p < RDP; p++) m_out[p] = nxt_out[p];
      if (s_wr && s_rd != 0) m_reg[s_rd] = wd;
      if (s_wr) m_busy[s_rd] = 0;
      if (s_iss && s_ird != 0) m_busy[s_ird] = 1;
    end
  endtask

  task automatic idle();
    reset = 1; wr_en = 0; load = 0; rd = '0; result = '0; memory = '0;
    rd_en = '0; rs_addr = '0; issue_en = 0; issue_rd = '0;
  endtask

  task automatic set_reads(logic [RDP-1:0] en, logic [AW-1:0] a0, logic [AW-1:0] a1);
    rd_en = en;
    rs_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    tick();
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data);
    end
    idle();
    set_reads(2'b01, 5, 0);
    #1;
    checks++;
    if (rs_busy !== 2'b00) begin
      errors++; $display("FAIL reset_rs_busy got %b exp 00", rs_busy);
    end
    tick();
    checks++;
    if (out_of(0) !== 32'h0) begin
      errors++; $display("FAIL reset_read_x5 got %h exp 0", out_of(0));
    end
  endtask

  task automatic test_write_select();
    idle();
    wr_en = 1; rd = 3; load = 0; result = 32'hDEADBEEF; memory = 32'hAAAA5555;
    tick();
    rd = 4; load = 1; memory = 32'h12345678; result = 32'h0BADF00D;
    tick();
    idle();
    set_reads(2'b11, 3, 4);
    tick();
    checks++;
    if (out_of(0) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sel_result_x3 got %h exp deadbeef", out_of(0));
    end
    checks++;
    if (out_of(1) !== 32'h12345678) begin
      errors++; $display("FAIL sel_memory_x4 got %h exp 12345678", out_of(1));
    end
    // Port 1 is not strobed, so it must hold its value.
    set_reads(2'b01, 4, 3);
    tick();
    checks++;
    if (out_of(1) !== 32'h12345678) begin
      errors++; $display("FAIL hold_port1 got %h exp 12345678", out_of(1));
    end
  endtask

  task automatic test_x0();
    idle();
    wr_en = 1; rd = 0; result = 32'hFFFFFFFF;
    tick();
    idle();
    set_reads(2'b11, 0, 0);
    tick();
    for (int p = 0; p < RDP; p++) begin
      checks++;
      if (out_of(p) !== 32'h0) begin
        errors++; $display("FAIL x0_read_port%0d got %h exp 0", p, out_of(p));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] exp_first;
`ifdef REGFILE_BYPASS_EN
    exp_first = 32'h22;
`else
    exp_first = 32'h11;
`endif
    idle();
    wr_en = 1; rd = 7; result = 32'h11;
    tick();
    result = 32'h22;
    set_reads(2'b01, 7, 0);
    tick();
    checks++;
    if (out_of(0) !== exp_first) begin
      errors++; $display("FAIL same_cycle_read got %h exp %h", out_of(0), exp_first);
    end
    idle();
    set_reads(2'b01, 7, 0);
    tick();
    checks++;
    if (out_of(0) !== 32'h22) begin
      errors++; $display("FAIL after_write_read got %h exp 22", out_of(0));
    end
  endtask

  task automatic test_scoreboard();
    bit exp_mask;
    idle();
    issue_en = 1; issue_rd = 9;
    tick();
    idle();
    set_reads(2'b00, 9, 9);
    #1;
    checks++;
    if (rs_busy !== 2'b11) begin
      errors++; $display("FAIL busy_set got %b exp 11", rs_busy);
    end
    // A writer to x9 with port 0 reading x9 may mask port 0 only.
    wr_en = 1; rd = 9; result = 32'h99;
    set_reads(2'b01, 9, 9);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_mask = 0;
`else
    exp_mask = 1;
`endif
    checks++;
    if (rs_busy !== {1'b1, exp_mask}) begin
      errors++; $display("FAIL busy_bypass_mask got %b exp %b", rs_busy, {1'b1, exp_mask});
    end
    tick();
    idle();
    set_reads(2'b00, 9, 0);
    #1;
    checks++;
    if (rs_busy[0] !== 1'b0) begin
      errors++; $display("FAIL busy_clear got %b exp 0", rs_busy[0]);
    end
    issue_en = 1; issue_rd = 9; wr_en = 1; rd = 9; result = 32'h9A;
    tick();
    idle();
    set_reads(2'b00, 9, 0);
    #1;
    checks++;
    if (rs_busy[0] !== 1'b1) begin
      errors++; $display("FAIL busy_set_wins got %b exp 1", rs_busy[0]);
    end
    issue_en = 1; issue_rd = 0;
    tick();
    idle();
    set_reads(2'b00, 0, 9);
    #1;
    checks++;
    if (rs_busy[0] !== 1'b0) begin
      errors++; $display("FAIL busy_x0 got %b exp 0", rs_busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    issue_en = 1; issue_rd = 9; wr_en = 1; rd = 2; result = 32'h55;
    tick();
    idle();
    reset = 0; wr_en = 1; rd = 2; result = 32'h66;
    issue_en = 1; issue_rd = 10; rd_en = 2'b11;
    tick();
    idle();
    set_reads(2'b01, 2, 9);
    #1;
    checks++;
    if (rs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_busy9 got %b exp 0", rs_busy[1]);
    end
    tick();
    checks++;
    if (out_of(0) !== 32'h0) begin
      errors++; $display("FAIL reset_mid_x2 got %h exp 0", out_of(0));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) != 0);
      wr_en    = $urandom_range(0, 1);
      load     = $urandom_range(0, 1);
      rd       = $urandom_range(0, 7);
      result   = $urandom;
      memory   = $urandom;
      rd_en    = $urandom_range(0, 3);
      rs_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      issue_en = $urandom_range(0, 1);
      issue_rd = $urandom_range(0, 7);
      #1;
      for (int p = 0; p < RDP; p++) begin
        checks++;
        if (rs_busy[p] !== model_busy(p)) begin
          errors++;
          $display("FAIL rand_busy%0d cyc %0d got %b exp %b", p, n, rs_busy[p], model_busy(p));
        end
      end
      tick();
      for (int p = 0; p < RDP; p++) begin
        checks++;
        if (out_of(p) !== m_out[p]) begin
          errors++;
          $display("FAIL rand_rd%0d cyc %0d got %h exp %h", p, n, out_of(p), m_out[p]);
        end
      end
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    for (int p = 0; p < RDP; p++) m_out[p] = '0;
    test_reset();
    test_write_select();
    test_x0();
    test_same_cycle();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers, power of two, minimum 2.
REQ-003 SHALL have parameter RD_PORTS, default 2: number of independent read ports, range 1..4.
REQ-004 SHALL define derived localparam AW = $clog2(NREG): register address width.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous reset, active-low (reset==0 resets on the rising edge of clk).
REQ-007 SHALL have port wr_en, input, 1 bit: commit write to register rd.
REQ-008 SHALL have port load, input, 1 bit: write-data select; 1 = memory, 0 = result.
REQ-009 SHALL have port rd, input, AW bits: write address.
REQ-010 SHALL have ports result and memory, input, XLEN bits each: ALU and load write data.
REQ-011 SHALL have port rd_en, input, RD_PORTS bits: per-port read strobe.
REQ-012 SHALL have port rs_addr, input, RD_PORTS*AW bits: packed read addresses; port p uses slice [p*AW +: AW].
REQ-013 SHALL have port rd_data, output reg, RD_PORTS*XLEN bits: packed registered read data; port p uses slice [p*XLEN +: XLEN].
REQ-014 SHALL have port issue_en, input, 1 bit: mark register issue_rd as pending-write.
REQ-015 SHALL have port issue_rd, input, AW bits: scoreboard set address.
REQ-016 SHALL have port rs_busy, output, RD_PORTS bits: combinational; per-port pending-write flag for rs_addr[p].

Function
REQ-017 SHALL hold NREG x XLEN storage; register 0 always reads 0, and writes to it SHALL be discarded.
REQ-018 SHALL, on the edge with wr_en=1 and rd!=0, write memory if load=1 and result otherwise.
REQ-019 SHALL give reads 1-cycle latency: on the edge with rd_en[p]=1, rd_data[p] loads reg[rs_addr[p]].
REQ-020 SHALL hold rd_data[p] unchanged on edges where rd_en[p]=0.
REQ-021 SHALL serve reads and writes in the same cycle; reads SHALL NOT be blocked by wr_en.
REQ-022 SHALL serve all read ports independently, including identical addresses on several ports.
REQ-023 SHALL keep an NREG-bit scoreboard busy[]; busy[0] SHALL always be 0.
REQ-024 SHALL set busy[issue_rd] on an edge with issue_en=1 and issue_rd!=0.
REQ-025 SHALL clear busy[rd] on an edge with wr_en=1.
REQ-026 SHALL, for issue_en and wr_en on the same edge with issue_rd==rd, leave busy[rd]=1 (set wins).
REQ-027 SHALL drive rs_busy[p] = busy[rs_addr[p]], subject to REQ-032.
REQ-028 SHALL wrap no address: every address is within NREG by construction, and AW-bit inputs SHALL be used as-is.

Reset
REQ-029 SHALL, on an edge with reset=0, clear all registers, all busy bits and all rd_data to 0.
REQ-030 SHALL give reset priority over wr_en, issue_en and rd_en on the same edge; a write or issue in that cycle SHALL be lost.

Configuration
REQ-031 SHALL use macro REGFILE_BYPASS_EN to enable write-to-read forwarding.
REQ-032 SHALL, with REGFILE_BYPASS_EN defined:
- when rd_en[p]=1, wr_en=1, rd!=0 and rd==rs_addr[p], load the incoming write data into rd_data[p];
- in that same condition, force rs_busy[p] to 0.
REQ-033 SHALL, without REGFILE_BYPASS_EN, make that same-cycle read return the pre-write value and leave rs_busy[p] unmasked.

Verification
REQ-034 SHALL test reset: reset=0 for 1 edge, then read x5 on port 0 -> rd_data[0]=0 one cycle later; rs_busy=0.
REQ-035 SHALL test the write select: wr_en=1, rd=3, load=0, result=0xDEADBEEF, then next edge load=1, rd=4, memory=0x12345678 -> reads x3=0xDEADBEEF and x4=0x12345678.
REQ-036 SHALL test x0: wr_en=1, rd=0, result=0xFFFFFFFF -> read x0 returns 0 on both ports.
REQ-037 SHALL test same-cycle write and read: x7=0x11, then wr_en=1, rd=7, result=0x22 with rd_en[0]=1, rs_addr[0]=7:
- with REGFILE_BYPASS_EN: rd_data[0]=0x22;
- without: rd_data[0]=0x11, and the next read returns 0x22.
REQ-038 SHALL test the scoreboard: issue_en=1, issue_rd=9 -> rs_busy=1 for rs_addr=9; wr_en, rd=9 -> clears; simultaneous issue and write to 9 -> busy stays 1.
REQ-039 SHALL test reset mid-operation: issue x9 and write x2=0x55, then reset=0 in the same cycle as wr_en, rd=2, result=0x66 -> x2=0 and busy[9]=0.
